// File: rtl/data_mem_responder.sv
// Load/store responder: one request at a time, programmable wait states,
// byte-lane store merge, load extension and alignment/range faulting.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t                state_reg, state_next;
  logic [3:0]            cnt_reg;
  logic                  we_reg;
  logic [2:0]            funct3_reg;
  logic [31:0]           addr_reg;
  logic [31:0]           wdata_reg;
  logic                  rsp_valid_reg;
  logic                  rsp_err_reg;
  logic [31:0]           rsp_rdata_reg;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           rd_word_reg;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic                  accept;
  logic                  access_err;
  logic                  mem_we;
  logic [3:0]            byte_en;
  logic [31:0]           lane_data;
  logic [31:0]           load_ext;
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;

  assign req_ready = (state_reg == S_IDLE);
  assign accept    = (state_reg == S_IDLE) && req_valid;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (req_valid) state_next = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (cnt_reg <= 4'd1) state_next = S_ACCESS;
      S_ACCESS: state_next = S_RESP;
      S_RESP:   if (rsp_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    access_err = 1'b0;
    if (addr_reg[31:ADDR_WIDTH+2] != '0) access_err = 1'b1;
    case (funct3_reg[1:0])
      2'd1:    if (addr_reg[0]) access_err = 1'b1;
      2'd2:    if (addr_reg[1:0] != 2'd0) access_err = 1'b1;
      default: ;
    endcase
    if (we_reg) begin
      if (funct3_reg > 3'd2) access_err = 1'b1;
    end else if (funct3_reg == 3'd3 || funct3_reg[2:1] == 2'b11) begin
      access_err = 1'b1;
    end
  end

  // Per-lane write enable and right-aligned store data steered to its lane.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_en[gi] = (funct3_reg[1:0] == 2'd2) ||
                           (funct3_reg[1:0] == 2'd1 && addr_reg[1] == 1'(gi / 2)) ||
                           (funct3_reg[1:0] == 2'd0 && addr_reg[1:0] == 2'(gi));
      assign lane_data[8*gi +: 8] = (funct3_reg[1:0] == 2'd0) ? wdata_reg[7:0] :
                                    (funct3_reg[1:0] == 2'd1) ? wdata_reg[8*(gi%2) +: 8] :
                                                                wdata_reg[8*gi +: 8];
    end
  endgenerate

  // The registered read lands on the edge that enters ACCESS; with no wait
  // states that is the accept edge, so the index comes straight off the request.
  assign rd_idx = accept ? req_addr[ADDR_WIDTH+1:2] : addr_reg[ADDR_WIDTH+1:2];
  assign wr_idx = addr_reg[ADDR_WIDTH+1:2];
  assign mem_we = (state_reg == S_ACCESS) && we_reg && !access_err && !reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[wr_idx][8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
    rd_word_reg <= mem[rd_idx];
  end

  assign sel_byte = rd_word_reg[{addr_reg[1:0], 3'b000} +: 8];
  assign sel_half = addr_reg[1] ? rd_word_reg[31:16] : rd_word_reg[15:0];

  always_comb begin
    load_ext = 32'd0;
    case (funct3_reg)
      3'd0:    load_ext = {{24{sel_byte[7]}}, sel_byte};
      3'd4:    load_ext = {24'd0, sel_byte};
      3'd1:    load_ext = {{16{sel_half[15]}}, sel_half};
      3'd5:    load_ext = {16'd0, sel_half};
      3'd2:    load_ext = rd_word_reg;
      default: load_ext = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_reg     <= req_we;
      funct3_reg <= req_funct3;
      addr_reg   <= req_addr;
      wdata_reg  <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= 4'd0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE:   if (req_valid) cnt_reg <= 4'(WAIT_STATES);
        S_WAIT:   cnt_reg <= cnt_reg - 4'd1;
        S_ACCESS: begin
          rsp_valid_reg <= 1'b1;
          rsp_err_reg   <= access_err;
          rsp_rdata_reg <= (we_reg || access_err) ? 32'd0 : load_ext;
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid_reg <= 1'b0;
          rsp_err_reg   <= 1'b0;
          rsp_rdata_reg <= 32'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-level reference memory, per-cycle compare
// of the handshake/response outputs, plus a zero-wait-state instance.
module tb_data_mem_responder;
  localparam int AW        = 10;
  localparam int W0        = 2;
  localparam int MEM_BYTES = 4 * (2 ** AW);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, rsp_rdata;

  logic        z_reset, z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [2:0]  z_req_funct3;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;

  data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(W0)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) u_dut_zero (
    .clk(clk), .reset(z_reset), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_we(z_req_we), .req_funct3(z_req_funct3), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: byte-addressed memory and the access rules in plain arithmetic.
  logic [7:0]  ref_mem [MEM_BYTES];
  bit          busy = 1'b0;
  bit          chk_en = 1'b0;
  int          accept_cyc = 0;
  logic [31:0] exp_rdata = 32'd0;
  logic        exp_err = 1'b0;

  function automatic void model_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                    input logic [31:0] wdata, output logic [31:0] rd, output logic err);
    int nb;
    bit sgn;
    logic [31:0] v;
    nb = 0;
    sgn = 1'b0;
    rd = 32'd0;
    if (we) begin
      case (f3)
        3'd0: nb = 1;
        3'd1: nb = 2;
        3'd2: nb = 4;
        default: nb = 0;
      endcase
    end else begin
      case (f3)
        3'd0: begin nb = 1; sgn = 1'b1; end
        3'd4: nb = 1;
        3'd1: begin nb = 2; sgn = 1'b1; end
        3'd5: nb = 2;
        3'd2: nb = 4;
        default: nb = 0;
      endcase
    end
    err = 1'b0;
    if (nb == 0) err = 1'b1;
    else if ((addr % nb) != 0) err = 1'b1;
    else if (addr >= MEM_BYTES) err = 1'b1;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8 * i));
        if (sgn && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        rd = v;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic ev;
      ev = busy && (cyc >= accept_cyc + W0 + 1);
      check("req_ready", 32'(req_ready), 32'(!busy));
      check("rsp_valid", 32'(rsp_valid), 32'(ev));
      check("rsp_rdata", rsp_rdata, ev ? exp_rdata : 32'd0);
      check("rsp_err", 32'(rsp_err), ev ? 32'(exp_err) : 32'd0);
    end
  end

  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold, input bit chk_lit,
                        input string lname, input logic [31:0] lit_data, input logic lit_err);
    logic [31:0] rd;
    logic e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    rsp_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    accept_cyc = cyc;
    model_txn(we, f3, addr, wdata, rd, e);
    exp_rdata = rd;
    exp_err = e;
    busy = 1'b1;
    req_valid = 1'b0;
    req_we = 1'($urandom_range(0, 1)); req_funct3 = 3'($urandom_range(0, 7));
    req_addr = $urandom; req_wdata = $urandom;
    do begin
      @(negedge clk);
      if (cyc < accept_cyc + W0 + 1) rsp_ready = 1'($urandom_range(0, 1));
      else begin
        rsp_ready = 1'b0;
        req_valid = 1'($urandom_range(0, 1));
      end
    end while (cyc < accept_cyc + W0 + 1 + hold);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    if (chk_lit) begin
      check({lname, "_rdata"}, rsp_rdata, lit_data);
      check({lname, "_err"}, 32'(rsp_err), 32'(lit_err));
    end
    $display("txn we=%0d f3=%0d addr=%08h wdata=%08h -> rdata=%08h err=%0d hold=%0d",
             we, f3, addr, wdata, rsp_rdata, rsp_err, hold);
    @(posedge clk); #1;
    busy = 1'b0;
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
  } zt_t;

  zt_t ztab[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, prev;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    z_reset = 1'b1; z_req_valid = 1'b0; z_req_we = 1'b0; z_req_funct3 = 3'd0;
    z_req_addr = 32'd0; z_req_wdata = 32'd0; z_rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 32; i++) do_txn(1'b1, 3'd2, 32'(i * 4), 32'd0, 0, 1'b0, "", 32'd0, 1'b0);

    do_txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 1'b1, "sw_10", 32'h0, 1'b0);
    do_txn(1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b1, "lw_10", 32'hDEADBEEF, 1'b0);

    do_txn(1'b1, 3'd2, 32'h20, 32'h11223344, 0, 1'b0, "", 32'd0, 1'b0);
    do_txn(1'b1, 3'd0, 32'h21, 32'hABCDEF80, 1, 1'b1, "sb_21", 32'h0, 1'b0);
    do_txn(1'b1, 3'd1, 32'h22, 32'h5555F00D, 0, 1'b0, "", 32'd0, 1'b0);
    do_txn(1'b0, 3'd2, 32'h20, 32'h0, 0, 1'b1, "lw_20", 32'hF00D8044, 1'b0);
    do_txn(1'b0, 3'd0, 32'h21, 32'h0, 0, 1'b1, "lb_21", 32'hFFFFFF80, 1'b0);
    do_txn(1'b0, 3'd4, 32'h21, 32'h0, 0, 1'b1, "lbu_21", 32'h00000080, 1'b0);
    do_txn(1'b0, 3'd1, 32'h22, 32'h0, 0, 1'b1, "lh_22", 32'hFFFFF00D, 1'b0);
    do_txn(1'b0, 3'd5, 32'h22, 32'h0, 0, 1'b1, "lhu_22", 32'h0000F00D, 1'b0);

    do_txn(1'b0, 3'd2, 32'h22, 32'h0, 0, 1'b1, "err_lw_misalign", 32'h0, 1'b1);
    do_txn(1'b1, 3'd1, 32'h23, 32'hFFFF, 0, 1'b1, "err_sh_misalign", 32'h0, 1'b1);
    do_txn(1'b0, 3'd2, 32'h1000, 32'h0, 0, 1'b1, "err_lw_range", 32'h0, 1'b1);
    do_txn(1'b0, 3'd3, 32'h20, 32'h0, 0, 1'b1, "err_ld_f3", 32'h0, 1'b1);
    do_txn(1'b0, 3'd2, 32'h20, 32'h0, 0, 1'b1, "lw_20_after_err", 32'hF00D8044, 1'b0);

    do_txn(1'b0, 3'd2, 32'h20, 32'h0, 5, 1'b1, "lw_backpressure", 32'hF00D8044, 1'b0);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
      do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
             $urandom_range(0, 3), 1'b0, "", 32'd0, 1'b0);
    end

    // Store aborted by reset on its ACCESS edge: no response, no write.
    do_txn(1'b1, 3'd2, 32'h30, 32'h0, 0, 1'b0, "", 32'd0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    accept_cyc = cyc;
    exp_rdata = 32'd0;
    exp_err = 1'b0;
    busy = 1'b1;
    req_valid = 1'b0;
    while (cyc < accept_cyc + W0) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    busy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    $display("txn reset-on-access sw addr=00000030 wdata=cafef00d aborted");
    do_txn(1'b0, 3'd2, 32'h30, 32'h0, 0, 1'b1, "lw_30_after_reset", 32'h0, 1'b0);

    // Zero-wait-state instance: back-to-back requests, rsp_ready tied high.
    ztab[0] = '{1'b1, 3'd2, 32'h40, 32'h12345678, 32'h0, 1'b0};
    ztab[1] = '{1'b0, 3'd2, 32'h40, 32'h0, 32'h12345678, 1'b0};
    ztab[2] = '{1'b0, 3'd4, 32'h43, 32'h0, 32'h00000012, 1'b0};
    ztab[3] = '{1'b1, 3'd1, 32'h42, 32'h9999ABCD, 32'h0, 1'b0};
    ztab[4] = '{1'b0, 3'd1, 32'h42, 32'h0, 32'hFFFFABCD, 1'b0};
    ztab[5] = '{1'b0, 3'd4, 32'h41, 32'h0, 32'h00000056, 1'b0};
    ztab[6] = '{1'b0, 3'd2, 32'h41, 32'h0, 32'h0, 1'b1};
    @(negedge clk);
    z_reset = 1'b0;
    prev = 0;
    for (int i = 0; i < 7; i++) begin
      int k;
      z_req_valid = 1'b1; z_req_we = ztab[i].we; z_req_funct3 = ztab[i].f3;
      z_req_addr = ztab[i].addr; z_req_wdata = ztab[i].wdata;
      k = 0;
      while (!z_req_ready && k < 8) begin
        @(negedge clk);
        k++;
      end
      check("z_accept_wait", 32'(k < 8), 32'd1);
      @(posedge clk); #1;
      acc = cyc;
      if (i > 0) check("z_accept_spacing", 32'(acc - prev), 32'd3);
      prev = acc;
      @(negedge clk);
      check("z_valid_access", 32'(z_rsp_valid), 32'd0);
      @(negedge clk);
      check("z_valid_resp", 32'(z_rsp_valid), 32'd1);
      check("z_rdata", z_rsp_rdata, ztab[i].rd);
      check("z_err", 32'(z_rsp_err), 32'(ztab[i].err));
      $display("ztxn we=%0d f3=%0d addr=%08h -> rdata=%08h err=%0d", ztab[i].we, ztab[i].f3,
               ztab[i].addr, z_rsp_rdata, z_rsp_err);
    end
    z_req_valid = 1'b0;

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
